// File: rtl/sprite_pkg.sv
// Shared sprite constants and motion-state encoding, used by both the
// motion controller and the renderer so the two always agree on geometry.
package sprite_pkg;

    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int SPRITE_WIDTH  = 100;
    localparam int SPRITE_HEIGHT = 75;

    // Largest legal top-left corner that keeps the sprite fully on screen.
    localparam int XMAX = SCREEN_W - SPRITE_WIDTH;
    localparam int YMAX = SCREEN_H - SPRITE_HEIGHT;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } motion_state_t;

endpackage

// File: rtl/sprite_motion_ctrl_btn_sync.sv
// Two-flop synchroniser for the raw gamepad button levels.
module btn_sync #(
    parameter int W = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Both stages clear on reset so no stale press survives it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: synchronised buttons -> sprite position,
// updated only on frame_tick with a slow-to-fast speed ramp.
// Optional build macro: SPRITE_WRAP_EN (wrap at the screen edges instead of clamping).
//
//   state | meaning
//   ------+---------------------------------------------------------
//   STOP  | no direction held; position frozen
//   SLOW  | held for up to RAMP_FRAMES frames; SLOW_STEP px per frame
//   FAST  | held past the ramp; FAST_STEP px per frame
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int SLOW_STEP   = 1,
    parameter int FAST_STEP   = 4,
    parameter int RAMP_FRAMES = 16,
    parameter int INIT_X      = 270,
    parameter int INIT_Y      = 202
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic [9:0] sprite_x,
    output logic [8:0] sprite_y,
    output logic       moving,
    output logic       edge_hit
);

    localparam int RW = $clog2(RAMP_FRAMES + 1);

    localparam logic signed [10:0] XMAX_S = 11'(XMAX);
    localparam logic signed [9:0]  YMAX_S = 10'(YMAX);

    logic [4:0]        btn_s;
    logic              s_up, s_down, s_left, s_right, s_center;
    logic              held;
    motion_state_t     state;
    logic [RW-1:0]     ramp_cnt;
    logic signed [10:0] step_w;
    logic signed [10:0] off_x, x_sum, x_new;
    logic signed [9:0]  off_y, y_sum, y_new;
    logic               clip_x, clip_y;

    btn_sync #(.W(5)) u_btn_sync (
        .CLK (CLK),
        .RST (RST),
        .d   ({btn_center, btn_right, btn_left, btn_down, btn_up}),
        .q   (btn_s)
    );

    assign {s_center, s_right, s_left, s_down, s_up} = btn_s;

    // Opposing buttons cancel, so "held" needs a net direction on some axis.
    assign held = (s_right ^ s_left) | (s_down ^ s_up);

    // Step size for this frame; when nothing is held the offsets are zero anyway.
    always_comb begin
        step_w = 11'(SLOW_STEP);
        if (state == FAST || (state == SLOW && ramp_cnt == RW'(RAMP_FRAMES)))
            step_w = 11'(FAST_STEP);
    end

    // Signed next-position arithmetic followed by clamp (or wrap) into range.
    always_comb begin
        off_x = '0;
        off_y = '0;
        if (s_right && !s_left) off_x = step_w;
        if (s_left && !s_right) off_x = -step_w;
        if (s_down && !s_up)    off_y = step_w[9:0];
        if (s_up && !s_down)    off_y = -step_w[9:0];

        x_sum  = $signed({1'b0, sprite_x}) + off_x;
        y_sum  = $signed({1'b0, sprite_y}) + off_y;
        x_new  = x_sum;
        y_new  = y_sum;
        clip_x = 1'b0;
        clip_y = 1'b0;
`ifdef SPRITE_WRAP_EN
        if (x_sum < 0) begin
            x_new  = x_sum + XMAX_S + 11'sd1;
            clip_x = 1'b1;
        end else if (x_sum > XMAX_S) begin
            x_new  = x_sum - XMAX_S - 11'sd1;
            clip_x = 1'b1;
        end
        if (y_sum < 0) begin
            y_new  = y_sum + YMAX_S + 10'sd1;
            clip_y = 1'b1;
        end else if (y_sum > YMAX_S) begin
            y_new  = y_sum - YMAX_S - 10'sd1;
            clip_y = 1'b1;
        end
`else
        if (x_sum < 0) begin
            x_new  = '0;
            clip_x = 1'b1;
        end else if (x_sum > XMAX_S) begin
            x_new  = XMAX_S;
            clip_x = 1'b1;
        end
        if (y_sum < 0) begin
            y_new  = '0;
            clip_y = 1'b1;
        end else if (y_sum > YMAX_S) begin
            y_new  = YMAX_S;
            clip_y = 1'b1;
        end
`endif
    end

    // Motion FSM with registered position, moving and edge_hit outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= STOP;
            ramp_cnt <= '0;
            sprite_x <= 10'(INIT_X);
            sprite_y <= 9'(INIT_Y);
            moving   <= 1'b0;
            edge_hit <= 1'b0;
        end else begin
            edge_hit <= 1'b0;
            if (frame_tick) begin
                if (s_center) begin
                    state    <= STOP;
                    ramp_cnt <= '0;
                    sprite_x <= 10'(INIT_X);
                    sprite_y <= 9'(INIT_Y);
                    moving   <= 1'b0;
                end else if (!held) begin
                    state    <= STOP;
                    ramp_cnt <= '0;
                    moving   <= 1'b0;
                end else begin
                    sprite_x <= x_new[9:0];
                    sprite_y <= y_new[8:0];
                    edge_hit <= clip_x | clip_y;
                    moving   <= 1'b1;
                    case (state)
                        STOP: begin
                            state    <= SLOW;
                            ramp_cnt <= RW'(1);
                        end
                        SLOW: begin
                            if (ramp_cnt == RW'(RAMP_FRAMES))
                                state <= FAST;
                            else
                                ramp_cnt <= ramp_cnt + RW'(1);
                        end
                        default: state <= FAST;
                    endcase
                end
            end
        end
    end

endmodule
